// File: rtl/ex_mem_latch_pkg.sv
// ex_mem_latch_pkg
//   Shared definitions for the EX/MEM pipeline register.
//   - DW, RW, CNTW : default datapath, register-specifier and counter widths
//   - state_t      : two-state halt FSM encoding
//   - ctrl_t       : per-instruction control bits carried into MEM
//   - CTRL_BUBBLE  : bubble encoding (every control bit 0)
package ex_mem_latch_pkg;

  localparam int DW   = 16;
  localparam int RW   = 3;
  localparam int CNTW = 8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic reg_wr_en;
    logic mem_rd;
    logic mem_wr;
    logic halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_latch_fwd_compare.sv
// fwd_compare
//   Pure combinational source/destination matching for MEM->EX forwarding.
//   Inputs : registered MEM-stage valid / reg_wr_en / mem_rd / wr_reg,
//            EX-stage source specifiers rs and rt.
//   Outputs: fwd_a, fwd_b (forward ALU result to operand A / B),
//            load_use (a load in MEM feeds EX; EX must stall one cycle).
module fwd_compare #(
  parameter int RW = 3
) (
  input  logic          mem_valid,
  input  logic          mem_reg_wr_en,
  input  logic          mem_mem_rd,
  input  logic [RW-1:0] mem_wr_reg,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  output logic          fwd_a,
  output logic          fwd_b,
  output logic          load_use
);

  logic writes;
  logic match_rs;
  logic match_rt;

  assign writes   = mem_valid & mem_reg_wr_en;
  assign match_rs = writes & (mem_wr_reg == ex_rs);
  assign match_rt = writes & (mem_wr_reg == ex_rt);

  // A load's data is not available until after MEM, so a load match turns
  // into a stall request instead of a forward.
  assign fwd_a    = match_rs & ~mem_mem_rd;
  assign fwd_b    = match_rt & ~mem_mem_rd;
  assign load_use = mem_mem_rd & (match_rs | match_rt);

endmodule

// File: rtl/ex_mem_latch.sv
// ex_mem_latch
//   EX/MEM pipeline register with stall, flush and halt, MEM->EX forwarding
//   detection and sticky/counted overflow status.
//   Inputs : clk, rst (sync, active high), stall, flush, ex_* instruction
//            fields from the execute stage, ex_rs/ex_rt source specifiers.
//   Outputs: mem_* registered instruction fields, fwd_a/fwd_b/load_use
//            (combinational), halted, ofl_sticky, ofl_count.
//   Edge priority: rst > flush > stall > halted bubble > capture.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int DW   = ex_mem_latch_pkg::DW,
  parameter int RW   = ex_mem_latch_pkg::RW,
  parameter int CNTW = ex_mem_latch_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [DW-1:0]   ex_alu_out,
  input  logic            ex_ofl,
  input  logic [RW-1:0]   ex_wr_reg,
  input  logic            ex_reg_wr_en,
  input  logic            ex_mem_rd,
  input  logic            ex_mem_wr,
  input  logic            ex_halt,
  input  logic [RW-1:0]   ex_rs,
  input  logic [RW-1:0]   ex_rt,
  output logic            mem_valid,
  output logic [DW-1:0]   mem_alu_out,
  output logic            mem_ofl,
  output logic [RW-1:0]   mem_wr_reg,
  output logic            mem_reg_wr_en,
  output logic            mem_mem_rd,
  output logic            mem_mem_wr,
  output logic            mem_halt,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic            load_use,
  output logic            halted,
  output logic            ofl_sticky,
  output logic [CNTW-1:0] ofl_count
);

  state_t          state_reg;
  ctrl_t           ctrl_reg;
  ctrl_t           ex_ctrl;
  logic [DW-1:0]   alu_reg;
  logic            ofl_reg;
  logic [RW-1:0]   wr_reg_reg;
  logic            sticky_reg;
  logic [CNTW-1:0] count_reg;
  logic            capture;
  logic            count_evt;

  // Control bits of the incoming instruction; an invalid slot becomes a bubble.
  always_comb begin
    ex_ctrl = CTRL_BUBBLE;
    if (ex_valid) begin
      ex_ctrl.valid     = 1'b1;
      ex_ctrl.reg_wr_en = ex_reg_wr_en;
      ex_ctrl.mem_rd    = ex_mem_rd;
      ex_ctrl.mem_wr    = ex_mem_wr;
      ex_ctrl.halt      = ex_halt;
    end
  end

  // An edge captures only when nothing of higher priority claims it.
  assign capture   = ~flush & ~stall & (state_reg == ST_RUN);
  assign count_evt = capture & ex_valid & ex_ofl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_RUN;
      ctrl_reg   <= CTRL_BUBBLE;
      alu_reg    <= '0;
      ofl_reg    <= 1'b0;
      wr_reg_reg <= '0;
      sticky_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (flush) begin
        ctrl_reg   <= CTRL_BUBBLE;
        alu_reg    <= '0;
        ofl_reg    <= 1'b0;
        wr_reg_reg <= '0;
      end else if (stall) begin
        ctrl_reg   <= ctrl_reg;
        alu_reg    <= alu_reg;
        ofl_reg    <= ofl_reg;
        wr_reg_reg <= wr_reg_reg;
      end else if (state_reg == ST_HALTED) begin
        ctrl_reg   <= CTRL_BUBBLE;
        alu_reg    <= '0;
        ofl_reg    <= 1'b0;
        wr_reg_reg <= '0;
      end else begin
        ctrl_reg   <= ex_ctrl;
        alu_reg    <= ex_alu_out;
        ofl_reg    <= ex_ofl;
        wr_reg_reg <= ex_wr_reg;
      end

      // HALTED is absorbing; only rst returns to RUN.
      if (capture && ex_valid && ex_halt) begin
        state_reg <= ST_HALTED;
      end

      if (count_evt) begin
        sticky_reg <= 1'b1;
        if (count_reg != {CNTW{1'b1}}) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  assign mem_valid     = ctrl_reg.valid;
  assign mem_reg_wr_en = ctrl_reg.reg_wr_en;
  assign mem_mem_rd    = ctrl_reg.mem_rd;
  assign mem_mem_wr    = ctrl_reg.mem_wr;
  assign mem_halt      = ctrl_reg.halt;
  assign mem_alu_out   = alu_reg;
  assign mem_ofl       = ofl_reg;
  assign mem_wr_reg    = wr_reg_reg;
  assign halted        = (state_reg == ST_HALTED);
  assign ofl_sticky    = sticky_reg;
  assign ofl_count     = count_reg;

  fwd_compare #(
    .RW(RW)
  ) u_fwd_compare (
    .mem_valid     (ctrl_reg.valid),
    .mem_reg_wr_en (ctrl_reg.reg_wr_en),
    .mem_mem_rd    (ctrl_reg.mem_rd),
    .mem_wr_reg    (wr_reg_reg),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .load_use      (load_use)
  );

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch
//   Directed self-checking bench for ex_mem_latch: reset, capture,
//   forwarding / load-use, stall, flush, overflow saturation, halt and
//   reset-out-of-halt.
module tb_ex_mem_latch;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_ofl, ex_reg_wr_en, ex_mem_rd, ex_mem_wr, ex_halt;
  logic [15:0] ex_alu_out;
  logic [2:0]  ex_wr_reg, ex_rs, ex_rt;
  logic        mem_valid, mem_ofl, mem_reg_wr_en, mem_mem_rd, mem_mem_wr, mem_halt;
  logic [15:0] mem_alu_out;
  logic [2:0]  mem_wr_reg;
  logic        fwd_a, fwd_b, load_use, halted, ofl_sticky;
  logic [7:0]  ofl_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_ofl(ex_ofl),
    .ex_wr_reg(ex_wr_reg), .ex_reg_wr_en(ex_reg_wr_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_ofl(mem_ofl),
    .mem_wr_reg(mem_wr_reg), .mem_reg_wr_en(mem_reg_wr_en),
    .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_halt(mem_halt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use), .halted(halted),
    .ofl_sticky(ofl_sticky), .ofl_count(ofl_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [15:0] alu, input logic [2:0] wr,
                        input logic wen, input logic rd, input logic wr_m,
                        input logic hlt, input logic ofl);
    ex_valid = v; ex_alu_out = alu; ex_wr_reg = wr; ex_reg_wr_en = wen;
    ex_mem_rd = rd; ex_mem_wr = wr_m; ex_halt = hlt; ex_ofl = ofl;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_rs = 3'd0; ex_rt = 3'd0;
    set_ex(1'b1, 16'hFFFF, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset: everything zero, FSM in RUN.
    tick(); tick();
    chk("rst_valid", mem_valid, 0);
    chk("rst_alu", mem_alu_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_sticky", ofl_sticky, 0);
    chk("rst_count", ofl_count, 0);
    chk("rst_halt", mem_halt, 0);
    $display("reset checked");

    // Capture.
    rst = 1'b0;
    set_ex(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("cap_alu", mem_alu_out, 16'h1234);
    chk("cap_wr_reg", mem_wr_reg, 3);
    chk("cap_valid", mem_valid, 1);
    chk("cap_wen", mem_reg_wr_en, 1);
    $display("capture alu=%h wr=%0d", mem_alu_out, mem_wr_reg);

    // Forwarding from a non-load in MEM (combinational from ex_rs/ex_rt).
    ex_rs = 3'd3; ex_rt = 3'd5; #1;
    chk("fwd_a_hit", fwd_a, 1);
    chk("fwd_b_miss", fwd_b, 0);
    chk("lu_nonload", load_use, 0);
    ex_rs = 3'd5; ex_rt = 3'd3; #1;
    chk("fwd_a_miss", fwd_a, 0);
    chk("fwd_b_hit", fwd_b, 1);
    $display("forward rs=%0d rt=%0d fwd_a=%b fwd_b=%b", ex_rs, ex_rt, fwd_a, fwd_b);

    // Load in MEM to r3 -> load-use instead of forwarding.
    set_ex(1'b1, 16'h0042, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    ex_rs = 3'd3; ex_rt = 3'd5; #1;
    chk("ld_fwd_a", fwd_a, 0);
    chk("ld_use_rs", load_use, 1);
    ex_rs = 3'd1; ex_rt = 3'd3; #1;
    chk("ld_fwd_b", fwd_b, 0);
    chk("ld_use_rt", load_use, 1);
    ex_rs = 3'd1; ex_rt = 3'd2; #1;
    chk("ld_use_none", load_use, 0);
    $display("load-use rd=%b load_use=%b", mem_mem_rd, load_use);

    // No write enable -> no forward.
    set_ex(1'b1, 16'h0001, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    ex_rs = 3'd4; ex_rt = 3'd4; #1;
    chk("nowen_fwd_a", fwd_a, 0);
    chk("nowen_mem_wr", mem_mem_wr, 1);

    // Stall three cycles while inputs change.
    set_ex(1'b1, 16'hAAAA, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ex(1'b1, 16'h1000 + 16'(k), 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("stall_alu", mem_alu_out, 16'hAAAA);
      chk("stall_wr_reg", mem_wr_reg, 2);
      chk("stall_rd", mem_mem_rd, 0);
      $display("stall cycle %0d alu=%h", k, mem_alu_out);
    end
    chk("stall_no_count", ofl_count, 0);
    stall = 1'b0;
    set_ex(1'b1, 16'h5555, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("unstall_alu", mem_alu_out, 16'h5555);

    // Stall and flush together: flush wins.
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("sf_valid", mem_valid, 0);
    chk("sf_wen", mem_reg_wr_en, 0);
    $display("stall+flush valid=%b", mem_valid);
    stall = 1'b0;

    // Overflow: flushed edges never count.
    set_ex(1'b1, 16'h7FFF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("flush_count", ofl_count, 0);
    chk("flush_sticky", ofl_sticky, 0);
    flush = 1'b0;
    ex_valid = 1'b0; tick();
    chk("invalid_count", ofl_count, 0);
    ex_valid = 1'b1; tick();
    chk("first_count", ofl_count, 1);
    chk("first_sticky", ofl_sticky, 1);
    chk("first_mem_ofl", mem_ofl, 1);
    for (int k = 1; k < 300; k++) tick();
    chk("sat_count", ofl_count, 255);
    chk("sat_sticky", ofl_sticky, 1);
    $display("overflow count=%0d sticky=%b", ofl_count, ofl_sticky);

    // Halt.
    set_ex(1'b1, 16'h0BAD, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("halt_mem_halt", mem_halt, 1);
    chk("halt_halted", halted, 1);
    chk("halt_valid", mem_valid, 1);
    set_ex(1'b1, 16'h2222, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hbub_valid", mem_valid, 0);
      chk("hbub_halted", halted, 1);
      chk("hbub_halt", mem_halt, 0);
      $display("halted cycle %0d valid=%b", k, mem_valid);
    end

    // Reset while halted, then a normal capture.
    rst = 1'b1;
    tick();
    chk("hrst_halted", halted, 0);
    chk("hrst_valid", mem_valid, 0);
    chk("hrst_count", ofl_count, 0);
    chk("hrst_sticky", ofl_sticky, 0);
    chk("hrst_alu", mem_alu_out, 0);
    rst = 1'b0;
    set_ex(1'b1, 16'hBEEF, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_alu", mem_alu_out, 16'hBEEF);
    chk("post_valid", mem_valid, 1);
    chk("post_halted", halted, 0);
    $display("post-reset capture alu=%h", mem_alu_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

EX/MEM pipeline register that sits directly downstream of the execute-stage ALU. It captures the 16-bit ALU result and overflow flag with the instruction's control bits each cycle, and supports stall, flush and halt. It also drives MEM→EX forwarding and load-use hazard signals back to the execute stage, and keeps sticky and counted overflow status for debug.

## Interface
Parameters:
- DW, 16, datapath width (ALU result width)
- RW, 3, register-specifier width
- CNTW, 8, overflow event counter width

Ports (name, direction, width, meaning):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all pipeline registers this cycle
- flush  in  1  load a bubble this cycle
- ex_valid  in  1  execute stage holds a real instruction
- ex_alu_out  in  DW  ALU result
- ex_ofl  in  1  ALU overflow flag
- ex_wr_reg  in  RW  destination register
- ex_reg_wr_en  in  1  instruction writes the register file
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store
- ex_halt  in  1  instruction is HALT
- ex_rs  in  RW  first source register of the instruction currently in EX
- ex_rt  in  RW  second source register of the instruction currently in EX
- mem_valid, mem_alu_out, mem_ofl, mem_wr_reg, mem_reg_wr_en, mem_mem_rd, mem_mem_wr, mem_halt  out  (widths match the ex_ inputs)  registered copies of the ex_ inputs
- fwd_a  out  1  forward mem_alu_out to ALU operand A
- fwd_b  out  1  forward mem_alu_out to ALU operand B
- load_use  out  1  EX must stall one cycle (load in MEM feeds EX)
- halted  out  1  FSM is in HALTED
- ofl_sticky  out  1  at least one valid overflow since reset
- ofl_count  out  CNTW  saturating count of valid overflows

## Operation
- FSM has two states, RUN and HALTED. Reset state is RUN.
- RUN → HALTED on a capturing edge (not stall, not flush) with ex_valid=1 and ex_halt=1. The halt instruction itself is latched (mem_halt=1).
- HALTED is left only by rst.
- Update priority per edge: rst > flush > stall > HALTED-bubble > capture.
  - rst: every output register goes to 0.
  - flush: mem_valid=0 and all mem_* control bits=0. mem_alu_out is don't-care; the implementation loads 0. Flush wins over a simultaneous stall.
  - stall: every mem_* register holds its value.
  - HALTED, no stall/flush: load a bubble (same as flush).
  - capture: load all ex_* inputs. When ex_valid=0, load control bits as 0 (bubble).
- Overflow status:
  - Counts only on a capture edge with ex_valid=1 and ex_ofl=1.
  - On such an edge, ofl_sticky is set to 1.
  - ofl_count increments and saturates at 2^CNTW-1.
  - Flushed, stalled and bubble edges never count.
  - Only rst clears these.
- Forwarding, combinational from the registered state:
  - match_x = mem_valid & mem_reg_wr_en & (mem_wr_reg == x).
  - fwd_a = match_rs & ~mem_mem_rd.
  - fwd_b = match_rt & ~mem_mem_rd.
  - load_use = mem_mem_rd & (match_rs | match_rt).
  - fwd_a/fwd_b and load_use are mutually exclusive per operand.
- ex_ofl is latched unchanged. Whether it is meaningful (ADD only) is decided upstream.

## Timing
- Latency is 1 cycle: ex_* sampled at edge N appears on mem_* after edge N.
- All mem_*, halted, ofl_sticky and ofl_count are registered. After rst they read 0 and halted=0.
- fwd_a, fwd_b and load_use are combinational, with zero cycles from mem_* and ex_rs/ex_rt. They settle within the same cycle for use by the EX operand muxes.
- Stall held for K cycles keeps the outputs constant for K cycles. On the first edge after stall drops, the current ex_* is captured.
- When rst is asserted mid-halt, or together with flush or stall, rst wins and the FSM is in RUN after the edge.

## Structure
- Shared header defines RW, DW and the bubble encoding (all control bits 0).
- One sub-module, fwd_compare: pure combinational source/destination matching that produces fwd_a, fwd_b and load_use.
- The rest is a single flat register block plus the two-state FSM.

## Test plan
- Reset, then capture: ex_valid=1, ex_alu_out=16'h1234, ex_wr_reg=3, ex_reg_wr_en=1 → next cycle mem_alu_out=16'h1234, mem_wr_reg=3, mem_valid=1.
- Forwarding: mem_wr_reg=3 with reg_wr_en set, ex_rs=3, ex_rt=5 → fwd_a=1, fwd_b=0, load_use=0. Set mem_mem_rd=1 → fwd_a=0, load_use=1.
- Stall 3 cycles while ex_* changes → mem_* constant. Assert stall and flush on the same edge → mem_valid=0.
- Overflow: 300 valid captures with ex_ofl=1, plus 5 flushed ones → ofl_count=255, ofl_sticky=1.
- Halt: capture ex_halt=1 → mem_halt=1, halted=1. On the next edges, valid inputs yield mem_valid=0.
- Assert rst while halted → halted=0 and all outputs 0. The next capture works normally.
